mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single req/ack memory port. Sits between the fetch stage (instruction requester, port I) and the memory stage (data requester, port D) on one side and the memory/bus on the other side (port M). Latches the winning request, holds it stable on port M until ack, and routes the response back to the owner. Data has priority, with a bounded streak so fetch cannot starve.

---
 rtl/riscv_mem_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 17 +
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and encodings for the memory port arbiter.
package riscv_mem_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STREAK_W = 4;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Request payload latched at grant and presented on port M.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              write;
        logic              extend;
        logic [1:0]        width;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data first, fetch forced after a bounded D streak.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_c,
    output logic                owner_c
);

    assign grant_c = i_req | d_req;
    assign owner_c = (d_req && (!i_req || (streak < STREAK_W'(MAX_D_STREAK)))) ? OWNER_D : OWNER_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single req/ack memory port.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_extend,
    input  logic [1:0]        d_width,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_write,
    output logic              m_extend,
    output logic [1:0]        m_width,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_t          state;
    mem_req_t            req_q;
    logic [STREAK_W-1:0] streak;
    logic                grant_c;
    logic                pick_c;

    mem_arb_pick #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .streak (streak),
        .grant_c(grant_c),
        .owner_c(pick_c)
    );

    // Grant in IDLE, hold the latched request until the memory acknowledges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            owner  <= OWNER_I;
            req_q  <= '0;
            streak <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_c) begin
                        state <= ARB_BUSY;
                        owner <= pick_c;
                        if (pick_c == OWNER_D) begin
                            req_q <= '{addr: d_addr, wdata: d_wdata, write: d_write,
                                       extend: d_extend, width: d_width};
                        end else begin
                            req_q <= '{addr: i_addr, wdata: '0, write: 1'b0,
                                       extend: 1'b0, width: WIDTH_W};
                        end
                    end
                    // Streak only counts D wins that actually made fetch wait.
                    if (!i_req) begin
                        streak <= '0;
                    end else if (pick_c == OWNER_D) begin
                        if (streak < STREAK_W'(MAX_D_STREAK)) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else begin
                        streak <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (m_ack) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state == ARB_BUSY);
    assign m_req    = busy;
    assign m_addr   = req_q.addr;
    assign m_wdata  = req_q.wdata;
    assign m_write  = req_q.write;
    assign m_extend = req_q.extend;
    assign m_width  = req_q.width;

    // Completion is steered to the owner in the same cycle as m_ack.
    assign i_ack   = busy & m_ack & (owner == OWNER_I);
    assign d_ack   = busy & m_ack & (owner == OWNER_D);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int unsigned MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_write, d_extend, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_width;
    logic        i_ack, d_ack, m_req, m_write, m_extend, busy, owner;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_width;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
        .d_extend(d_extend), .d_width(d_width), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write),
        .m_extend(m_extend), .m_width(m_width), .m_ack(m_ack), .m_rdata(m_rdata),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: one outstanding transfer plus the fetch-wait count.
    bit          mb, mo, mwr, mex, ip, dp, dwin, ei, ed;
    logic [31:0] ma, mw;
    logic [1:0]  mwd;
    int          ms;
    logic        order_exp [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_extend = 1'b0;
        m_ack = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_width = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_width", 32'(m_width), 0);
        reset_n = 1'b1;

        // Single load with immediate m_ack
        d_req = 1'b1; d_addr = 32'h100; d_width = 2'd2; d_write = 1'b0;
        tick();
        chk("load_m_req", m_req, 1);
        chk("load_m_addr", m_addr, 32'h100);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        #2;
        chk("load_d_ack", d_ack, 1);
        chk("load_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("load_i_ack", i_ack, 0);
        tick();
        d_req = 1'b0; m_ack = 1'b0;
        chk("load_idle", busy, 0);

        // Fetch with m_ack delayed three cycles
        i_req = 1'b1; i_addr = 32'h4;
        tick();
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("fetch_m_req", m_req, 1);
            chk("fetch_m_addr", m_addr, 32'h4);
            chk("fetch_m_write", m_write, 0);
            chk("fetch_m_width", 32'(m_width), 2);
            chk("fetch_i_ack_wait", i_ack, 0);
            tick();
        end
        m_ack = 1'b1;
        #2;
        chk("fetch_i_ack", i_ack, 1);
        chk("fetch_d_ack", d_ack, 0);
        tick();
        i_req = 1'b0; m_ack = 1'b0;
        chk("fetch_idle", busy, 0);

        // Both requesting continuously
        i_req = 1'b1; d_req = 1'b1; m_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("order_%0d", k), owner, 32'(order_exp[k]));
            tick();
        end
        i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
        tick();

        // Byte store
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_width = 2'd0;
        tick();
        chk("store_m_write", m_write, 1);
        chk("store_m_wdata", m_wdata, 32'h12345678);
        chk("store_m_width", 32'(m_width), 0);
        chk("store_m_addr", m_addr, 32'h200);
        m_ack = 1'b1;
        #2;
        chk("store_d_ack", d_ack, 1);
        tick();
        d_req = 1'b0; d_write = 1'b0; m_ack = 1'b0;

        // Reset while waiting on m_ack
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        chk("rmid_busy_pre", busy, 1);
        reset_n = 1'b0; i_req = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rmid_m_req", m_req, 0);
        chk("rmid_busy", busy, 0);
        m_ack = 1'b1;
        #2;
        chk("rmid_i_ack", i_ack, 0);
        chk("rmid_d_ack", d_ack, 0);
        tick();

        // Spurious m_ack in IDLE
        chk("spur_i_ack", i_ack, 0);
        chk("spur_d_ack", d_ack, 0);
        tick();
        chk("spur_busy", busy, 0);
        chk("spur_m_req", m_req, 0);
        m_ack = 1'b0;

        // Randomized traffic against the model, starting from a clean reset
        reset_n = 1'b0;
        tick();
        mb = 0; mo = 0; mwr = 0; mex = 0; ma = '0; mw = '0; mwd = '0; ms = 0; ip = 0; dp = 0;
        for (int c = 0; c < 2000; c++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; i_addr = $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; d_addr = $urandom; d_wdata = $urandom;
                d_write = 1'($urandom_range(0, 1)); d_extend = 1'($urandom_range(0, 1));
                d_width = 2'($urandom_range(0, 2));
            end
            i_req = ip; d_req = dp;
            m_ack = reset_n && ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;
            #2;
            ei = mb && m_ack && !mo;
            ed = mb && m_ack && mo;
            chk("rnd_busy", busy, 32'(mb));
            chk("rnd_m_req", m_req, 32'(mb));
            if (mb) chk("rnd_owner", owner, 32'(mo));
            chk("rnd_m_addr", m_addr, ma);
            chk("rnd_m_wdata", m_wdata, mw);
            chk("rnd_m_write", m_write, 32'(mwr));
            chk("rnd_m_extend", m_extend, 32'(mex));
            chk("rnd_m_width", 32'(m_width), 32'(mwd));
            chk("rnd_i_ack", i_ack, 32'(ei));
            chk("rnd_d_ack", d_ack, 32'(ed));
            chk("rnd_i_rdata", i_rdata, m_rdata);
            chk("rnd_d_rdata", d_rdata, m_rdata);
            if (ei) ip = 0;
            if (ed) dp = 0;
            if (!reset_n) begin
                mb = 0; mo = 0; mwr = 0; mex = 0; ma = '0; mw = '0; mwd = '0; ms = 0;
            end else if (mb) begin
                if (m_ack) mb = 0;
            end else if (i_req || d_req) begin
                dwin = d_req && (!i_req || ms < int'(MAX));
                mb = 1; mo = dwin;
                if (dwin) begin
                    ma = d_addr; mw = d_wdata; mwr = d_write; mex = d_extend; mwd = d_width;
                end else begin
                    ma = i_addr; mw = '0; mwr = 0; mex = 0; mwd = 2'd2;
                end
                if (dwin && i_req) ms = (ms + 1 > int'(MAX)) ? int'(MAX) : ms + 1;
                else ms = 0;
            end else begin
                ms = 0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
